// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// frame-result encoding and the row/column -> key-code layout.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } kp_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } frame_kind_t;

    // One frame's verdict; code is meaningful only for RES_SINGLE.
    typedef struct packed {
        frame_kind_t kind;
        logic [3:0]  code;
    } frame_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam int         BIN_MAX   = 255;

    function automatic logic [3:0] layout_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, bundled for port lists.
interface keypad_scanner_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] bin;

    modport master (
        output key_row,
        input  key_col, key_code, key_valid, key_held, bin
    );

    modport slave (
        input  key_row,
        output key_col, key_code, key_valid, key_held, bin
    );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce: needs DEBOUNCE_FRAMES matching frame results to
// accept a press or a release. Acts only on frame_end strobes.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_end,
    input  frame_t     frame,
    output logic       take,
    output logic [3:0] take_code,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int             CW       = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    kp_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc   = cnt + CNT_ONE;
    // In PRESS_CHK an accept implies frame.code == cand, so the frame code
    // is always the code being accepted.
    assign take_code = frame.code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_valid <= take;
            if (take) key_code <= take_code;
            key_held  <= (state_n == HELD) || (state_n == RELEASE_CHK);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        take    = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame.kind == RES_SINGLE) begin
                        cand_n = frame.code;
                        if (CNT_ONE == CNT_DONE) begin
                            state_n = HELD;
                            cnt_n   = '0;
                            take    = 1'b1;
                        end else begin
                            state_n = PRESS_CHK;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (frame.kind == RES_SINGLE && frame.code == cand) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_n = HELD;
                            cnt_n   = '0;
                            take    = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (frame.kind == RES_NONE) begin
                        if (CNT_ONE == CNT_DONE) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            state_n = RELEASE_CHK;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end
                RELEASE_CHK: begin
                    if (frame.kind == RES_NONE) begin
                        if (cnt_inc == CNT_DONE) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, classifies
// each 4-slot frame, debounces, and accumulates decimal entry into bin.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.slave   kif
);

    localparam int             SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [11:0]    BIN_LIMIT = 12'(BIN_MAX);

    logic [3:0]    row_s1, row_s2;
    logic [SW-1:0] slot_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    hit_cnt;
    logic [3:0]    hit_code;
    logic [7:0]    bin_q;

    logic          slot_end, frame_end;
    logic [3:0]    row_hit;
    logic [2:0]    n_hits, tot;
    logic [1:0]    first_row;
    logic [3:0]    slot_code;
    frame_t        frame;
    logic          take;
    logic [3:0]    take_code;
    logic [11:0]   bin_calc;

    assign kif.key_col = ~(4'b0001 << col_idx);
    assign kif.bin     = bin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= kif.key_row;
            row_s2 <= row_s1;
        end
    end

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (col_idx == 2'd3);
    assign row_hit   = ~row_s2;
    assign n_hits    = popcnt4(row_hit);
    assign tot       = 3'(hit_cnt) + n_hits;

    // Lowest pressed row wins; only relevant when this slot is the sole hit.
    always_comb begin
        first_row = '0;
        for (int r = 3; r >= 0; r--)
            if (row_hit[r]) first_row = 2'(r);
    end

    assign slot_code = layout_code(first_row, col_idx);

    always_comb begin
        frame.code = (hit_cnt != 2'd0) ? hit_code : slot_code;
        if (tot == 3'd0)      frame.kind = RES_NONE;
        else if (tot == 3'd1) frame.kind = RES_SINGLE;
        else                  frame.kind = RES_MULTI;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            col_idx  <= '0;
            hit_cnt  <= '0;
            hit_code <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            if (frame_end) begin
                hit_cnt <= '0;
            end else begin
                // Saturate at 2: anything above one hit is just MULTI.
                hit_cnt <= (tot > 3'd2) ? 2'd2 : tot[1:0];
                if (hit_cnt == 2'd0 && n_hits != 3'd0) hit_code <= slot_code;
            end
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .frame     (frame),
        .take      (take),
        .take_code (take_code),
        .key_valid (kif.key_valid),
        .key_code  (kif.key_code),
        .key_held  (kif.key_held)
    );

    assign bin_calc = {4'b0, bin_q} * 12'd10 + {8'b0, take_code};

    // bin updates on the accept edge so it is already new while key_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
        end else if (take) begin
            if (take_code == KEY_CLEAR)
                bin_q <= '0;
            else if (take_code <= 4'd9 && bin_calc <= BIN_LIMIT)
                bin_q <= bin_calc[7:0];
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: pulled-up keypad matrix model,
// expected key events in a scoreboard queue, table of press/release taps.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_scanner_if kif();

    logic [3:0][3:0] pressed;  // [row][col]

    always_comb begin
        for (int r = 0; r < 4; r++)
            kif.key_row[r] = ~|(pressed[r] & ~kif.key_col);
    end

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    typedef struct {
        logic [3:0] code;
        logic [7:0] bin;
    } exp_t;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
        logic [7:0] bin;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_chk = 0;
    int   n_fail = 0;
    int   valid_seen = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every key_valid pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && kif.key_valid === 1'b1) begin
            valid_seen++;
            check("valid_pulse_width", {31'b0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: key_code=%0h bin=%0d with nothing expected",
                         kif.key_code, kif.bin);
            end else begin
                e = sb.pop_front();
                check("sb_key_code", {28'b0, kif.key_code}, {28'b0, e.code});
                check("sb_bin", {24'b0, kif.bin}, {24'b0, e.bin});
                check("sb_held_on_valid", {31'b0, kif.key_held}, 32'd1);
            end
        end
        prev_valid = kif.key_valid;
    end

    task automatic wait_valid(input int target, input int budget, input string name);
        int k = 0;
        while (valid_seen < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'b0, valid_seen >= target}, 32'd1);
    endtask

    task automatic wait_frame_start();
        int k = 0;
        while (kif.key_col !== 4'b0111 && k < 64) begin @(negedge clk); k++; end
        while (kif.key_col !== 4'b1110 && k < 64) begin @(negedge clk); k++; end
        check("frame_sync", {31'b0, k < 64}, 32'd1);
    endtask

    task automatic tap(input vec_t v, input int idx);
        int t = valid_seen;
        sb.push_back('{v.code, v.bin});
        pressed[v.r][v.c] = 1'b1;
        wait_valid(t + 1, 120, $sformatf("tap%0d_valid", idx));
        repeat (16) @(negedge clk);
        pressed[v.r][v.c] = 1'b0;
        repeat (80) @(negedge clk);
        check($sformatf("tap%0d_released", idx), {31'b0, kif.key_held}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_key_col"},   {28'b0, kif.key_col},   32'hE);
        check({tag, "_key_code"},  {28'b0, kif.key_code},  32'h0);
        check({tag, "_key_valid"}, {31'b0, kif.key_valid}, 32'h0);
        check({tag, "_key_held"},  {31'b0, kif.key_held},  32'h0);
        check({tag, "_bin"},       {24'b0, kif.bin},       32'h0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int v0;
        pressed = '0;
        vecs[0] = '{0, 3, 4'hA, 8'd0};
        vecs[1] = '{0, 1, 4'h2, 8'd2};
        vecs[2] = '{1, 1, 4'h5, 8'd25};
        vecs[3] = '{1, 1, 4'h5, 8'd255};
        vecs[4] = '{1, 2, 4'h6, 8'd255};   // 2556 > 255: dropped
        vecs[5] = '{0, 3, 4'hA, 8'd0};
        vecs[6] = '{0, 1, 4'h2, 8'd2};
        vecs[7] = '{1, 1, 4'h5, 8'd25};
        vecs[8] = '{1, 2, 4'h6, 8'd25};    // 256 > 255: dropped
        vecs[9] = '{0, 3, 4'hA, 8'd0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (SCAN_DIV) @(negedge clk);
        check("col_rotate", {28'b0, kif.key_col}, 32'hD);

        // Single steady key 5: one pulse, held until three empty frames.
        v0 = valid_seen;
        sb.push_back('{4'h5, 8'd5});
        pressed[1][1] = 1'b1;
        wait_valid(v0 + 1, 120, "t1_valid");
        check("t1_held", {31'b0, kif.key_held}, 32'd1);
        repeat (48) @(negedge clk);
        check("t1_no_repeat", valid_seen, v0 + 1);
        pressed[1][1] = 1'b0;
        repeat (16) @(negedge clk);
        check("t1_held_after_release", {31'b0, kif.key_held}, 32'd1);
        repeat (64) @(negedge clk);
        check("t1_released", {31'b0, kif.key_held}, 32'd0);

        for (int i = 0; i < 10; i++) tap(vecs[i], i);

        // Bounce on key 3: present, absent, present, present, released.
        wait_frame_start();
        v0 = valid_seen;
        pressed[0][2] = 1'b1;
        repeat (16) @(negedge clk);
        pressed[0][2] = 1'b0;
        repeat (16) @(negedge clk);
        pressed[0][2] = 1'b1;
        repeat (32) @(negedge clk);
        pressed[0][2] = 1'b0;
        repeat (64) @(negedge clk);
        check("bounce_no_valid", valid_seen, v0);
        check("bounce_not_held", {31'b0, kif.key_held}, 32'd0);

        // Keys 1 and 9 together are MULTI; dropping 9 leaves a clean 1.
        v0 = valid_seen;
        pressed[0][0] = 1'b1;
        pressed[2][2] = 1'b1;
        repeat (160) @(negedge clk);
        check("multi_no_valid", valid_seen, v0);
        check("multi_not_held", {31'b0, kif.key_held}, 32'd0);
        sb.push_back('{4'h1, 8'd1});
        pressed[2][2] = 1'b0;
        wait_valid(v0 + 1, 120, "multi_then_single_valid");
        repeat (16) @(negedge clk);
        pressed[0][0] = 1'b0;
        repeat (80) @(negedge clk);
        check("multi_released", {31'b0, kif.key_held}, 32'd0);

        // Reset while key 7 is held, then it is reported again.
        v0 = valid_seen;
        sb.push_back('{4'h7, 8'd17});
        pressed[2][0] = 1'b1;
        wait_valid(v0 + 1, 120, "rst_pre_valid");
        check("rst_pre_held", {31'b0, kif.key_held}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.push_back('{4'h7, 8'd7});
        wait_valid(v0 + 2, 120, "rst_post_valid");
        repeat (16) @(negedge clk);
        pressed[2][0] = 1'b0;
        repeat (80) @(negedge clk);
        check("rst_released", {31'b0, kif.key_held}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the board's multiplexed 7-segment display driver. It scans a 4x4 matrix keypad by walking one active-low column strobe, the same way the display walks its digit selects.
- It samples the row lines, debounces across whole scan frames, and emits one event per key press.
- Decimal keys accumulate into an 8-bit binary value that feeds the display path directly.

Parameters:
- SCAN_DIV, 50000, clock cycles per column slot; must be >= 2.
- DEBOUNCE_FRAMES, 4, consecutive identical frame results required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- key_row  input  4  keypad rows; active-low (pulled up); asynchronous to clk.
- key_col  output  4  column strobes; one-hot-low; column index c drives bit c low.
- key_code  output  4  layout code of the last accepted key.
- key_valid  output  1  one-cycle pulse on press acceptance.
- key_held  output  1  high from press acceptance until release acceptance.
- bin  output  8  accumulated decimal entry value.

Behaviour:
- Reset values: key_col=4'b1110, key_code=0, key_valid=0, key_held=0, bin=0, all counters=0, state=IDLE.
- Reset mid-operation: everything returns to the reset values. A key still held after reset is reported again after a full debounce.
- Synchronization: key_row passes through a 2-flop synchronizer.
- Slot timing: a slot counter runs 0..SCAN_DIV-1. On the last cycle of each slot:
  - the synchronized rows are sampled for the current column;
  - key_col rotates left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- Frame: four slots, columns 0..3. During a frame the block counts low row bits and records the row/column of a hit. At frame end the frame result is one of:
  - NONE: zero hits.
  - SINGLE(code): exactly one hit.
  - MULTI: two or more hits.
- Layout codes (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- State machine (evaluated only at frame end):
  - IDLE: SINGLE(k) -> PRESS_CHK, cand=k, cnt=1. Otherwise stay.
  - PRESS_CHK: SINGLE(cand) -> cnt+1. Any other result -> IDLE, cnt=0. When cnt reaches DEBOUNCE_FRAMES -> HELD, with key_code=cand, a key_valid pulse and key_held=1.
  - HELD: NONE -> RELEASE_CHK, cnt=1. Any other result stays in HELD; there is no auto-repeat and a second key is ignored.
  - RELEASE_CHK: NONE -> cnt+1. Any other result -> HELD. When cnt reaches DEBOUNCE_FRAMES -> IDLE, key_held=0.
  - With DEBOUNCE_FRAMES=1, acceptance happens at the first qualifying frame end.
- Latency:
  - key_valid asserts in the cycle after the frame-end sample of the DEBOUNCE_FRAMES-th qualifying frame.
  - key_held rises in that same cycle.
- Entry accumulation (same cycle as key_valid, on the accepted key):
  - digit d (0..9): new = bin*10 + d, computed at 12 bits. If new <= 255, bin=new; otherwise bin is unchanged and the digit is dropped (no saturation, no wrap).
  - key A: bin=0.
  - keys B..F: no effect on bin; they still produce key_valid and update key_code.
- key_code holds its value until the next accepted press.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (IDLE, PRESS_CHK, HELD, RELEASE_CHK);
  - the frame-result encoding;
  - the 16-entry layout lookup (row, column -> code);
  - the constants KEY_CLEAR=4'hA and BIN_MAX=255.
- One sub-module, keypad_debounce: the frame-result state machine plus counter. It takes a frame_end strobe and the frame result, and outputs the accept pulse, the code and the held flag.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, 16 cycles per frame; row pull-ups modelled; the bench drives key_row from key_col):
- Hold row1/col1 steady -> exactly one key_valid pulse with key_code=5 about 3 frames after press; bin=5; key_held stays 1 until 3 NONE frames after release, then returns to 0.
- Press and release 2, 5, 5, then 6 -> bin goes 2, 25, 255; the 6 is dropped because 2556 > 255, so bin stays 255 while key_valid still pulses with key_code=6.
- Press and release 2, 5, then 6 -> bin stays 25 because 256 > 255; then press A -> bin=0 and key_code=A.
- Bounce: key 3 present in frame 1, absent in frame 2, present in frames 3 and 4, then released -> no key_valid, key_held stays 0.
- Keys 1 and 9 held together for 10 frames -> MULTI every frame, no key_valid; release 9 while keeping 1 -> key_valid with key_code=1 after 3 frames.
- Hold key 7 and assert rst for 3 cycles while key_held=1 -> all outputs at reset values immediately; after rst deasserts, key_valid with key_code=7 after 3 frames and bin=7.
